// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_ctrl
// Purpose  : Serial pattern detector with a three-state controller
//            (IDLE / ARMED / DONE) and a saturating match counter.
//            A PAT_W-bit pattern is loaded over a valid/ready handshake.
//            While ARMED, qualified serial bits are shifted in at the LSB.
//            A match produces a one-cycle registered pulse on z.
//            In one-shot mode the first match parks the FSM in DONE.
// Build option:
//            SEQ_OVERLAP_EN - when defined, the history is kept after a
//            match, so matches may overlap. When undefined, the fill
//            count restarts on every match, so matches do not overlap.
// Ports    :
//   clk          in   clock, rising edge
//   reset        in   asynchronous reset, active low
//   cfg_valid    in   pattern-load request
//   cfg_ready    out  load accepted (high in IDLE)
//   cfg_pattern  in   [PAT_W] pattern, MSB is the first serial bit
//   cfg_oneshot  in   one-shot mode bit, loaded with the pattern
//   start        in   arm the detector
//   stop         in   disarm the detector
//   cnt_clr      in   clear match counter and saturation flag
//   w            in   serial data bit
//   w_valid      in   w qualifier
//   z            out  registered one-cycle match pulse
//   busy         out  high in ARMED
//   done         out  high in DONE
//   match_cnt    out  [CNT_W] saturating match count
//   cnt_sat      out  sticky saturation flag
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    input  logic             cnt_clr,
    input  logic             w,
    input  logic             w_valid,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int                  c_FILL_W    = $clog2(PAT_W + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ARMED = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]          r_state;
    logic [PAT_W-1:0]    r_shift;
    logic [c_FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]    r_pattern;
    logic                r_oneshot;
    logic                r_pat_ok;
    logic                r_z;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sat;

    logic [PAT_W-1:0]    w_shift_nxt;
    logic [c_FILL_W-1:0] w_fill_nxt;
    logic                w_sample;
    logic                w_match;
    logic [CNT_W-1:0]    w_cnt_inc;

    // stop outranks w_valid, so a bit arriving together with stop is dropped
    assign w_sample    = (r_state == c_ARMED) && w_valid && !stop;
    assign w_shift_nxt = {r_shift[PAT_W-2:0], w};
    // The fill count stops at PAT_W; beyond that only the window content matters
    assign w_fill_nxt  = (r_fill == c_FILL_FULL) ? r_fill : r_fill + c_FILL_W'(1);
    assign w_match     = w_sample && (w_fill_nxt == c_FILL_FULL) &&
                         (w_shift_nxt == r_pattern);
    assign w_cnt_inc   = r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_IDLE;
            r_shift   <= '0;
            r_fill    <= '0;
            r_pattern <= '0;
            r_oneshot <= 1'b0;
            r_pat_ok  <= 1'b0;
            r_z       <= 1'b0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_z <= w_match;

            case (r_state)
                c_IDLE: begin
                    if (cfg_valid) begin
                        r_pattern <= cfg_pattern;
                        r_oneshot <= cfg_oneshot;
                        r_pat_ok  <= 1'b1;
                    end
                    // A load in this same cycle is enough to allow arming
                    if (start && (r_pat_ok || cfg_valid)) begin
                        r_state <= c_ARMED;
                        r_shift <= '0;
                        r_fill  <= '0;
                    end
                end
                c_ARMED: begin
                    if (stop) begin
                        r_state <= c_IDLE;
                        r_shift <= '0;
                        r_fill  <= '0;
                    end else if (w_valid) begin
                        r_shift <= w_shift_nxt;
`ifdef SEQ_OVERLAP_EN
                        r_fill  <= w_fill_nxt;
`else
                        r_fill  <= w_match ? '0 : w_fill_nxt;
`endif
                        if (w_match && r_oneshot) begin
                            r_state <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    if (stop) begin
                        r_state <= c_IDLE;
                        r_shift <= '0;
                        r_fill  <= '0;
                    end else if (start) begin
                        r_state <= c_ARMED;
                        r_shift <= '0;
                        r_fill  <= '0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            // Clear wins over a coincident increment
            if (cnt_clr) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (w_match && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == c_CNT_MAX) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign cfg_ready = (r_state == c_IDLE);
    assign busy      = (r_state == c_ARMED);
    assign done      = (r_state == c_DONE);
    assign z         = r_z;
    assign match_cnt = r_cnt;
    assign cnt_sat   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_ctrl
// Purpose  : Self-checking bench for seq_detect_ctrl. Directed scenarios are
//            followed by random traffic. A behavioural model predicts the
//            outputs for every cycle. A monitor compares those predictions
//            against the DUT. Match pulses are also checked against a
//            queue of predicted match cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int M_IDLE = 0, M_ARMED = 1, M_DONE = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_oneshot;
    logic             start, stop, cnt_clr, w, w_valid;
    logic             z, busy, done, cnt_sat;
    logic [CNT_W-1:0] match_cnt;

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_oneshot(cfg_oneshot), .start(start),
        .stop(stop), .cnt_clr(cnt_clr), .w(w), .w_valid(w_valid), .z(z),
        .busy(busy), .done(done), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit z, busy, done, rdy, sat;
        int cnt;
    } st_t;

    st_t sq[$];
    int  mq[$];
    int  n_vec = 0, n_err = 0, n_cmp = 0;

    // Behavioural model: the bit history since arming (or since the last
    // match in non-overlapping mode) is kept as a plain queue.
    int             m_state;
    bit [PAT_W-1:0] m_pat;
    bit             m_os, m_ok, m_z, m_sat;
    bit             m_hist[$];
    int             m_cnt;

    task automatic model_reset();
        m_state = M_IDLE; m_pat = '0; m_os = 0; m_ok = 0; m_z = 0;
        m_sat = 0; m_cnt = 0; m_hist.delete();
    endtask

    task automatic model_step(input bit rs, cv, input bit [PAT_W-1:0] pat,
                              input bit os, st, sp, cl, ww, wv);
        bit match = 0;
        int v;
        if (!rs) begin
            model_reset();
            return;
        end
        case (m_state)
            M_IDLE: begin
                if (cv) begin m_pat = pat; m_os = os; m_ok = 1; end
                if (st && m_ok) begin m_state = M_ARMED; m_hist.delete(); end
            end
            M_ARMED: begin
                if (sp) begin
                    m_state = M_IDLE;
                end else if (wv) begin
                    m_hist.push_back(ww);
                    if (m_hist.size() >= PAT_W) begin
                        v = 0;
                        for (int i = m_hist.size() - PAT_W; i < m_hist.size(); i++)
                            v = (v << 1) | int'(m_hist[i]);
                        match = (v == int'(m_pat));
                    end
`ifdef SEQ_OVERLAP_EN
                    if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
`else
                    if (match) m_hist.delete();
`endif
                    if (match && m_os) m_state = M_DONE;
                end
            end
            default: begin
                if (sp) m_state = M_IDLE;
                else if (st) begin m_state = M_ARMED; m_hist.delete(); end
            end
        endcase
        m_z = match;
        if (cl) begin
            m_cnt = 0; m_sat = 0;
        end else if (match) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (m_cnt == CNT_MAX) m_sat = 1;
        end
    endtask

    task automatic drive(input bit rs, cv, input bit [PAT_W-1:0] pat,
                         input bit os, st, sp, cl, ww, wv);
        st_t e;
        #1;
        reset = rs; cfg_valid = cv; cfg_pattern = pat; cfg_oneshot = os;
        start = st; stop = sp; cnt_clr = cl; w = ww; w_valid = wv;
        model_step(rs, cv, pat, os, st, sp, cl, ww, wv);
        @(posedge clk);
        n_vec++;
        e.cyc = n_vec; e.z = m_z; e.busy = (m_state == M_ARMED);
        e.done = (m_state == M_DONE); e.rdy = (m_state == M_IDLE);
        e.cnt = m_cnt; e.sat = m_sat;
        sq.push_back(e);
        if (m_z) mq.push_back(n_vec);
        @(negedge clk);
    endtask

    // Shorthands for the directed part (pattern 1011 unless loaded otherwise)
    task automatic bit_in(input bit b);
        drive(1, 0, 4'b1011, 0, 0, 0, 0, b, 1);
    endtask
    task automatic nop();
        drive(1, 0, 4'b1011, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic go();
        drive(1, 0, 4'b1011, 0, 1, 0, 0, 0, 0);
    endtask
    task automatic halt();
        drive(1, 0, 4'b1011, 0, 0, 1, 0, 0, 0);
    endtask
    task automatic pat1011();
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);
    endtask

    // Monitor: one status record per clock edge, plus match-pulse timing
    always @(negedge clk) begin
        st_t e;
        int  c;
        if (sq.size() > 0) begin
            e = sq.pop_front();
            n_cmp++;
            if (z !== e.z || busy !== e.busy || done !== e.done ||
                cfg_ready !== e.rdy || int'(match_cnt) != e.cnt || cnt_sat !== e.sat ||
                $isunknown({z, busy, done, cfg_ready, match_cnt, cnt_sat})) begin
                n_err++;
                $display("FAIL status cyc=%0d: got z=%b busy=%b done=%b rdy=%b cnt=%0d sat=%b, want z=%b busy=%b done=%b rdy=%b cnt=%0d sat=%b",
                         e.cyc, z, busy, done, cfg_ready, match_cnt, cnt_sat,
                         e.z, e.busy, e.done, e.rdy, e.cnt, e.sat);
            end
            if (z === 1'b1) begin
                n_cmp++;
                if (mq.size() == 0) begin
                    n_err++;
                    $display("FAIL z_pulse: got pulse at cyc=%0d, want no pulse", e.cyc);
                end else begin
                    c = mq.pop_front();
                    if (c != e.cyc) begin
                        n_err++;
                        $display("FAIL z_pulse: got pulse at cyc=%0d, want cyc=%0d", e.cyc, c);
                    end
                end
            end
        end
    end

    initial begin
        bit rs, cv, os, st, sp, cl, ww, wv;
        bit [PAT_W-1:0] pat;
        model_reset();
        reset = 0; cfg_valid = 0; cfg_pattern = '0; cfg_oneshot = 0;
        start = 0; stop = 0; cnt_clr = 0; w = 0; w_valid = 0;
        @(negedge clk);

        // Reset state
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // start without a loaded pattern is ignored
        go();
        // Load and start in the same cycle, then the basic stream
        drive(1, 1, 4'b1011, 0, 1, 0, 0, 0, 0);
        bit_in(1); bit_in(0); bit_in(1); bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        // Same stream with a three-cycle gap between bits 2 and 3
        halt(); drive(1, 0, 4'b1011, 0, 0, 0, 1, 0, 0); go();
        bit_in(1); bit_in(0); nop(); nop(); nop();
        bit_in(1); bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        // stop together with the final matching bit
        halt(); go();
        bit_in(1); bit_in(0); bit_in(1);
        drive(1, 0, 4'b1011, 0, 0, 1, 0, 1, 1);
        nop();
        // Saturation, then clear coincident with a further match
        go();
        repeat (5) pat1011();
        bit_in(1); bit_in(0); bit_in(1);
        drive(1, 0, 4'b1011, 0, 0, 0, 1, 1, 1);
        nop();
        // One-shot mode
        halt();
        drive(1, 1, 4'b1011, 1, 0, 0, 0, 0, 0);
        go();
        pat1011(); bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        go();
        pat1011();
        halt();
        // Reset part-way through a match
        drive(1, 1, 4'b1011, 0, 1, 0, 0, 0, 0);
        bit_in(1); bit_in(0); bit_in(1);
        drive(0, 0, 4'b1011, 0, 0, 0, 0, 1, 1);
        bit_in(1);
        nop();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rs  = ($urandom_range(0, 299) != 0);
            cv  = ($urandom_range(0, 9) == 0);
            pat = ($urandom_range(0, 1) != 0) ? 4'b1011 : PAT_W'($urandom);
            os  = ($urandom_range(0, 3) == 0);
            st  = ($urandom_range(0, 6) == 0);
            sp  = ($urandom_range(0, 39) == 0);
            cl  = ($urandom_range(0, 29) == 0);
            ww  = 1'($urandom);
            wv  = ($urandom_range(0, 9) < 7);
            drive(rs, cv, pat, os, st, sp, cl, ww, wv);
        end
        drive(1, 0, 4'b1011, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        n_cmp++;
        if (mq.size() != 0 || sq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pulses and %0d status records outstanding, want 0 and 0",
                     mq.size(), sq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
